register_file_param: RTL and testbench

Parametrised successor of the datapath's 8x16 register file: DEPTH = 2**ADDR_W registers, each DATA_W bits wide. One write port and two combinational read ports.
Adds a sequenced bulk-clear engine (one register per cycle, busy flag) and a sticky flag for writes dropped while clearing. Optionally, register 0 is hardwired to zero.
Sits in the Rechenwerk between the control unit (write port, clear request) and the ALU operand muxes (read ports).

---
 rtl/register_file_param_if.sv | 27 ++
 rtl/register_file_param.sv | 93 +++++++++
 tb/tb_register_file_param.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/register_file_param_if.sv
// Register file bus: write port, two read ports, bulk-clear request and status.
// The control unit drives through master; the register file attaches as slave.
interface register_file_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [DATA_W-1:0] wrData;
    logic [ADDR_W-1:0] wrAddr;
    logic              wrEn;
    logic [ADDR_W-1:0] rdAddr1;
    logic [ADDR_W-1:0] rdAddr2;
    logic [DATA_W-1:0] rdData1;
    logic [DATA_W-1:0] rdData2;
    logic              clrReq;
    logic              busy;
    logic              wrDropped;

    modport master (
        output wrData, wrAddr, wrEn, rdAddr1, rdAddr2, clrReq,
        input  rdData1, rdData2, busy, wrDropped
    );

    modport slave (
        input  wrData, wrAddr, wrEn, rdAddr1, rdAddr2, clrReq,
        output rdData1, rdData2, busy, wrDropped
    );
endinterface

// File: rtl/register_file_param.sv
// Parametrised register file: 1 write / 2 combinational read ports, sequenced bulk clear.
// Optional write-through forwarding on reads when REGFILE_BYPASS_EN is defined.
module register_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 0
) (
    input logic                  clk,
    input logic                  rst,
    register_file_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_wr_dropped;
    logic [DATA_W-1:0] w_regs [DEPTH];
    logic              w_idle;
    logic              w_clearing;
    logic              w_zero_hit;
    logic              w_wr_ok;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_clearing = (r_state == ST_CLEAR);
    assign w_zero_hit = (ZERO_REG != 0) && (bus.wrAddr == '0);
    assign w_wr_ok    = bus.wrEn && w_idle && !w_zero_hit;

    // Clear engine: counter walks 0..DEPTH-1 and wraps back to 0 on exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_wr_dropped <= 1'b0;
        end else if (w_idle) begin
            if (bus.clrReq) begin
                r_state <= ST_CLEAR;
                r_cnt   <= '0;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (bus.wrEn) begin
                r_wr_dropped <= 1'b1;
            end
            if (r_cnt == LAST_IDX) begin
                r_state <= ST_IDLE;
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] r_val;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_val <= '0;
                end else if (w_clearing && (r_cnt == IDX)) begin
                    r_val <= '0;
                end else if (w_wr_ok && (bus.wrAddr == IDX)) begin
                    r_val <= bus.wrData;
                end
            end
            assign w_regs[gi] = r_val;
        end
    end

    always_comb begin
        w_rd1 = w_regs[bus.rdAddr1];
        w_rd2 = w_regs[bus.rdAddr2];
`ifdef REGFILE_BYPASS_EN
        // Forward only writes that will actually land; never while in reset.
        if (rst && w_wr_ok && (bus.rdAddr1 == bus.wrAddr)) begin
            w_rd1 = bus.wrData;
        end
        if (rst && w_wr_ok && (bus.rdAddr2 == bus.wrAddr)) begin
            w_rd2 = bus.wrData;
        end
`else
`endif
    end

    assign bus.rdData1   = w_rd1;
    assign bus.rdData2   = w_rd2;
    assign bus.busy      = w_clearing;
    assign bus.wrDropped = r_wr_dropped;
endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: two DUTs (ZERO_REG=0 and 1) share stimulus; an array model predicts reads.
module tb_register_file_param;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          d_rst    = 1'b0;
    logic          d_wrEn   = 1'b0;
    logic          d_clrReq = 1'b0;
    logic [DW-1:0] d_wrData = '0;
    logic [AW-1:0] d_wrAddr = '0;
    logic [AW-1:0] d_rd1    = '0;
    logic [AW-1:0] d_rd2    = '0;

    register_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_a ();
    register_file_param_if #(.DATA_W(DW), .ADDR_W(AW)) if_b ();

    assign if_a.wrData = d_wrData;  assign if_b.wrData = d_wrData;
    assign if_a.wrAddr = d_wrAddr;  assign if_b.wrAddr = d_wrAddr;
    assign if_a.wrEn   = d_wrEn;    assign if_b.wrEn   = d_wrEn;
    assign if_a.rdAddr1 = d_rd1;    assign if_b.rdAddr1 = d_rd1;
    assign if_a.rdAddr2 = d_rd2;    assign if_b.rdAddr2 = d_rd2;
    assign if_a.clrReq = d_clrReq;  assign if_b.clrReq = d_clrReq;

    register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst(d_rst), .bus(if_a.slave));
    register_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(d_rst), .bus(if_b.slave));

    // Reference model: plain memories plus a "clear in progress" position.
    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_clear;
    int            m_pos;
    bit            m_drop;

    typedef struct {
        logic [DW-1:0] rd1a, rd2a, rd1b, rd2b;
        logic          busy, drop;
        int            cyc;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    function automatic void model_reset();
        for (int z = 0; z < 2; z++)
            for (int i = 0; i < DEPTH; i++) m_mem[z][i] = '0;
        m_clear = 0;
        m_pos   = 0;
        m_drop  = 0;
    endfunction

    function automatic logic [DW-1:0] model_read(int z, logic [AW-1:0] a);
        if (z == 1 && a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (!m_clear && d_rst && d_wrEn && d_wrAddr == a) return d_wrData;
`endif
        return m_mem[z][a];
    endfunction

    function automatic void model_edge();
        if (!d_rst) begin
            model_reset();
            return;
        end
        if (!m_clear) begin
            if (d_wrEn) begin
                m_mem[0][d_wrAddr] = d_wrData;
                if (d_wrAddr != 0) m_mem[1][d_wrAddr] = d_wrData;
            end
            if (d_clrReq) begin
                m_clear = 1;
                m_pos   = 0;
            end
        end else begin
            if (d_wrEn) m_drop = 1;
            m_mem[0][m_pos] = '0;
            m_mem[1][m_pos] = '0;
            m_pos++;
            if (m_pos == DEPTH) begin
                m_clear = 0;
                m_pos   = 0;
            end
        end
    endfunction

    task automatic step(input logic rst_v, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] ra1,
                        input logic [AW-1:0] ra2, input logic clr);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        d_rst = rst_v; d_wrEn = we; d_wrAddr = wa; d_wrData = wd;
        d_rd1 = ra1; d_rd2 = ra2; d_clrReq = clr;
        if (!d_rst) model_reset();
        cyc++;
        e.rd1a = model_read(0, ra1);
        e.rd2a = model_read(0, ra2);
        e.rd1b = model_read(1, ra1);
        e.rd2b = model_read(1, ra2);
        e.busy = m_clear;
        e.drop = m_drop;
        e.cyc  = cyc;
        sb_q.push_back(e);
    endtask

    task automatic idle(input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        step(1'b1, 1'b0, '0, '0, ra1, ra2, 1'b0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        step(1'b1, 1'b1, a, d, ra1, ra2, 1'b0);
    endtask

    function automatic void check(string nm, int c, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, exp);
        end
    endfunction

    // Monitor: outputs are combinational, so each cycle's response is sampled at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rd1_a", e.cyc, if_a.rdData1, e.rd1a);
                check("rd2_a", e.cyc, if_a.rdData2, e.rd2a);
                check("rd1_b", e.cyc, if_b.rdData1, e.rd1b);
                check("rd2_b", e.cyc, if_b.rdData2, e.rd2b);
                check("busy_a", e.cyc, {15'd0, if_a.busy}, {15'd0, e.busy});
                check("busy_b", e.cyc, {15'd0, if_b.busy}, {15'd0, e.busy});
                check("drop_a", e.cyc, {15'd0, if_a.wrDropped}, {15'd0, e.drop});
                check("drop_b", e.cyc, {15'd0, if_b.wrDropped}, {15'd0, e.drop});
                $display("[TB] cyc=%0d rst=%0b we=%0b wa=%0d wd=%h ra=%0d/%0d clr=%0b rdA=%h/%h rdB=%h/%h busy=%0b drop=%0b",
                         e.cyc, d_rst, d_wrEn, d_wrAddr, d_wrData, d_rd1, d_rd2, d_clrReq,
                         if_a.rdData1, if_a.rdData2, if_b.rdData1, if_b.rdData2,
                         if_a.busy, if_a.wrDropped);
            end
        end
    end

    initial begin
        model_reset();
        step(1'b0, 1'b0, '0, '0, 3'd0, 3'd7, 1'b0);
        step(1'b0, 1'b1, 3'd1, 16'hDEAD, 3'd1, 3'd7, 1'b0);

        // Basic write then read back
        wr(3'd5, 16'hBEEF, 3'd5, 3'd2);
        wr(3'd2, 16'h1234, 3'd5, 3'd2);
        idle(3'd5, 3'd2);
        idle(3'd7, 3'd0);

        // Fill all, bulk clear, observe partial progress
        for (int i = 0; i < DEPTH; i++)
            wr(AW'(i), 16'(16'h1111 * (i + 1)), AW'(i), AW'(i));
        step(1'b1, 1'b0, '0, '0, 3'd2, 3'd3, 1'b1);
        for (int k = 0; k < 10; k++) idle(AW'(k), AW'(k + 3));

        // Write during clear is dropped; clrReq during clear ignored
        wr(3'd7, 16'h7777, 3'd7, 3'd7);
        step(1'b1, 1'b0, '0, '0, 3'd7, 3'd0, 1'b1);
        idle(3'd7, 3'd6);
        wr(3'd7, 16'hAAAA, 3'd7, 3'd6);
        step(1'b1, 1'b0, '0, '0, 3'd7, 3'd5, 1'b1);
        for (int k = 0; k < 7; k++) idle(3'd7, AW'(k));

        // Write and clear request in the same idle cycle
        step(1'b0, 1'b0, '0, '0, 3'd0, 3'd0, 1'b0);
        step(1'b1, 1'b1, 3'd0, 16'h5555, 3'd0, 3'd1, 1'b1);
        for (int k = 0; k < 10; k++) idle(3'd0, AW'(k));

        // Reset in the middle of a clear
        wr(3'd3, 16'h3333, 3'd3, 3'd6);
        wr(3'd6, 16'h6060, 3'd3, 3'd6);
        step(1'b1, 1'b0, '0, '0, 3'd3, 3'd6, 1'b1);
        for (int k = 0; k < 3; k++) idle(3'd3, 3'd6);
        step(1'b0, 1'b0, '0, '0, 3'd3, 3'd6, 1'b0);
        step(1'b0, 1'b0, '0, '0, 3'd3, 3'd6, 1'b0);
        wr(3'd6, 16'h6666, 3'd6, 3'd3);
        idle(3'd6, 3'd3);

        // Register 0 writes and same-cycle forwarding
        wr(3'd0, 16'hFFFF, 3'd0, 3'd0);
        idle(3'd0, 3'd0);
        wr(3'd4, 16'h1357, 3'd4, 3'd0);
        wr(3'd4, 16'h00C3, 3'd4, 3'd4);
        idle(3'd4, 3'd4);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) != 0),
                 AW'($urandom), DW'($urandom), AW'($urandom), AW'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
